// File: rtl/token_decoder.sv
// token_decoder: checks a serial 1..N token frame over valid/ready,
// recovers N and the per-slot presence mask, and presents them downstream.
module token_decoder #(
  parameter int MAX_TOKENS = 7,
  parameter int TW         = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tok_valid,
  input  logic [TW-1:0]         tok_data,
  input  logic                  tok_last,
  output logic                  tok_ready,
  output logic                  val_valid,
  output logic [TW-1:0]         val_data,
  input  logic                  val_ready,
  output logic [MAX_TOKENS-1:0] tok_mask,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    OUT,
    DRAIN
  } state_t;

  localparam logic [TW:0] MAXT = (TW+1)'(MAX_TOKENS);
  localparam logic [TW:0] ONE  = (TW+1)'(1);

  state_t                state_q, state_n;
  logic [TW:0]           exp_q, exp_n;
  logic [TW-1:0]         cnt_q, cnt_n;
  logic [MAX_TOKENS-1:0] mask_q, mask_n;
  logic                  one_q, one_n;

  logic                  tok_acc;
  logic                  val_acc;
  logic                  is_zero;
  logic                  is_one;
  logic                  exp_ok;
  logic [MAX_TOKENS-1:0] slot;

  assign tok_ready = (state_q != OUT);
  assign val_valid = (state_q == OUT);
  assign err       = (state_q == DRAIN);
  assign val_data  = val_valid ? cnt_q : '0;
  assign tok_mask  = val_valid ? mask_q : '0;

  assign tok_acc = tok_valid && tok_ready;
  assign val_acc = val_valid && val_ready;
  assign is_zero = (tok_data == '0);
  assign is_one  = (tok_data == TW'(1));

  // exp is one bit wider than the token so MAX_TOKENS+1 never aliases
  assign exp_ok = ({1'b0, tok_data} == exp_q) && (exp_q <= MAXT);
  assign slot   = MAX_TOKENS'(1) << (exp_q - ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      exp_q   <= ONE;
      cnt_q   <= '0;
      mask_q  <= '0;
      one_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      exp_q   <= exp_n;
      cnt_q   <= cnt_n;
      mask_q  <= mask_n;
      one_q   <= one_n;
    end
  end

  always_comb begin
    state_n = state_q;
    exp_n   = exp_q;
    cnt_n   = cnt_q;
    mask_n  = mask_q;
    one_n   = one_q;
    unique case (state_q)
      IDLE: begin
        if (tok_acc) begin
          unique case (1'b1)
            is_zero && tok_last: begin
              state_n = OUT;
              cnt_n   = '0;
              mask_n  = '0;
            end
            is_one: begin
              state_n = tok_last ? OUT : COLLECT;
              mask_n  = MAX_TOKENS'(1);
              cnt_n   = TW'(1);
              exp_n   = (TW+1)'(2);
            end
            default: begin
              state_n = DRAIN;
              one_n   = tok_last;
            end
          endcase
        end
      end
      COLLECT: begin
        if (tok_acc) begin
          if (exp_ok) begin
            mask_n = mask_q | slot;
            cnt_n  = exp_q[TW-1:0];
            exp_n  = exp_q + ONE;
            if (tok_last) state_n = OUT;
          end else begin
            state_n = DRAIN;
            one_n   = tok_last;
          end
        end
      end
      OUT: begin
        if (val_acc) begin
          state_n = IDLE;
          exp_n   = ONE;
          cnt_n   = '0;
          mask_n  = '0;
        end
      end
      DRAIN: begin
        // a bad token that closed its own frame still costs one err cycle
        if (one_q || (tok_acc && tok_last)) begin
          state_n = IDLE;
          exp_n   = ONE;
          cnt_n   = '0;
          mask_n  = '0;
          one_n   = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
